// File: rtl/data_memory_pkg.sv
// data_memory_pkg: FSM state encoding and default sizing shared by the data memory block.
package data_memory_pkg;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;
  localparam int DEF_LINE_BITS = 256;
  localparam int DEF_DEPTH = 512;
  localparam int DEF_LATENCY = 10;
  localparam int DEF_ADDR_BITS = 32;
endpackage

// File: rtl/mem_line_array.sv
// mem_line_array: line storage with byte-enabled synchronous write and registered read, no reset.
module mem_line_array #(
  parameter int LINE_BITS = 256,
  parameter int DEPTH = 512,
  parameter int IDX_BITS = 9
) (
  input  logic                   clk_i,
  input  logic [IDX_BITS-1:0]    addr_i,
  input  logic                   we_i,
  input  logic [LINE_BITS/8-1:0] be_i,
  input  logic [LINE_BITS-1:0]   wdata_i,
  output logic [LINE_BITS-1:0]   rdata_o
);
  logic [LINE_BITS-1:0] mem_q [DEPTH];
  logic [LINE_BITS-1:0] rdata_q;
  always_ff @(posedge clk_i) begin
    if (we_i)
      for (int b = 0; b < LINE_BITS/8; b++)
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    rdata_q <= mem_q[addr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/param_data_memory.sv
// param_data_memory: fixed-latency line memory; one request in flight, ack/err pulse on completion.
module param_data_memory import data_memory_pkg::*; #(
  parameter int LINE_BITS = DEF_LINE_BITS,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [ADDR_BITS-1:0]   addr_i,
  input  logic [LINE_BITS-1:0]   data_i,
  input  logic [LINE_BITS/8-1:0] be_i,
  input  logic                   enable_i,
  input  logic                   write_i,
  output logic                   ready_o,
  output logic                   ack_o,
  output logic                   err_o,
  output logic [LINE_BITS-1:0]   data_o
);
  localparam int NB = LINE_BITS/8;
  localparam int OFF_BITS = $clog2(NB);
  localparam int IDX_BITS = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(LATENCY+1);
  localparam logic [CW-1:0] LAST = CW'(LATENCY-1);
  localparam logic [ADDR_BITS-1:0] DEPTH_A = ADDR_BITS'(DEPTH);

  logic                 state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [LINE_BITS-1:0] data_q, data_d;
  logic [NB-1:0]        be_q, be_d;
  logic                 wr_q, wr_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [LINE_BITS-1:0] dout_q, dout_d;
  logic                 accept, last, in_sel, mem_we;
  logic [ADDR_BITS-1:0] line_sel;
  logic [IDX_BITS-1:0]  mem_idx;
  logic [LINE_BITS-1:0] rd_data;

  // The read port is addressed with the incoming request on the accept edge so
  // that even LATENCY=1 has the line ready by the ack edge.
  always_comb begin
    accept = (state_q == ST_IDLE) && enable_i;
    last = (state_q == ST_WAIT) && (cnt_q == LAST);
    line_sel = (accept ? addr_i : addr_q) >> OFF_BITS;
    in_sel = line_sel < DEPTH_A;
    mem_idx = in_sel ? line_sel[IDX_BITS-1:0] : '0;
    mem_we = last && wr_q && in_sel;
    state_d = accept ? ST_WAIT : last ? ST_IDLE : state_q;
    cnt_d = accept ? '0 : (state_q == ST_WAIT) ? cnt_q + 1'b1 : cnt_q;
    addr_d = accept ? addr_i : addr_q;
    data_d = accept ? data_i : data_q;
    be_d = accept ? be_i : be_q;
    wr_d = accept ? write_i : wr_q;
    ack_d = last;
    err_d = last && !in_sel;
    dout_d = (last && !wr_q) ? (in_sel ? rd_data : '0) : dout_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      be_q <= '0;
      wr_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      be_q <= be_d;
      wr_q <= wr_d;
      ack_q <= ack_d;
      err_q <= err_d;
      dout_q <= dout_d;
    end
  end

  mem_line_array #(.LINE_BITS(LINE_BITS), .DEPTH(DEPTH), .IDX_BITS(IDX_BITS)) u_mem (
    .clk_i(clk_i),
    .addr_i(mem_idx),
    .we_i(mem_we),
    .be_i(be_q),
    .wdata_i(data_q),
    .rdata_o(rd_data)
  );

  assign ready_o = (state_q == ST_IDLE);
  assign ack_o = ack_q;
  assign err_o = err_q;
  assign data_o = dout_q;
endmodule
